// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with a valid/ready handshake and a 2-entry skid buffer.
// Optional back-pressure and flush statistics are built when PIPE_STAGE_STAT_EN is defined.
module pipe_stage_reg #(
    parameter int CTRL_W  = 8,
    parameter int DATA_W  = 32,
    parameter int DATA_CH = 4,
    parameter int ADDR_W  = 5,
    parameter int ADDR_CH = 3
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [CTRL_W-1:0]          in_ctrl_i,
    input  logic [DATA_CH*DATA_W-1:0]  in_data_i,
    input  logic [ADDR_CH*ADDR_W-1:0]  in_addr_i,
    input  logic                       bubble_i,
    input  logic                       flush_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [CTRL_W-1:0]          out_ctrl_o,
    output logic [DATA_CH*DATA_W-1:0]  out_data_o,
    output logic [ADDR_CH*ADDR_W-1:0]  out_addr_o,
    output logic [15:0]                stall_cnt_o,
    output logic [15:0]                flush_cnt_o
);

    localparam int DW = DATA_CH * DATA_W;
    localparam int AW = ADDR_CH * ADDR_W;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t            state_r;
    logic              valid_r;
    logic [CTRL_W-1:0] head_ctrl_r;
    logic [DW-1:0]     head_data_r;
    logic [AW-1:0]     head_addr_r;
    logic [CTRL_W-1:0] skid_ctrl_r;
    logic [DW-1:0]     skid_data_r;
    logic [AW-1:0]     skid_addr_r;

    logic              acc_s;
    logic              pop_s;
    logic [CTRL_W-1:0] in_ctrl_s;

    assign in_ready_o  = !rst_i && (state_r != ST_SKID);
    assign acc_s       = in_valid_i && in_ready_o;
    assign pop_s       = valid_r && out_ready_i;

    assign out_valid_o = valid_r;
    assign out_ctrl_o  = head_ctrl_r;
    assign out_data_o  = head_data_r;
    assign out_addr_o  = head_addr_r;

    // Bubble insertion zeroes only the control field of the incoming packet.
    always_comb begin
        in_ctrl_s = in_ctrl_i;
        if (bubble_i) begin
            in_ctrl_s = {CTRL_W{1'b0}};
        end else begin
            in_ctrl_s = in_ctrl_i;
        end
    end

    // Handshake FSM and head/skid storage.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= ST_EMPTY;
            valid_r     <= 1'b0;
            head_ctrl_r <= {CTRL_W{1'b0}};
            head_data_r <= {DW{1'b0}};
            head_addr_r <= {AW{1'b0}};
            skid_ctrl_r <= {CTRL_W{1'b0}};
            skid_data_r <= {DW{1'b0}};
            skid_addr_r <= {AW{1'b0}};
        end else if (flush_i) begin
            // Data is left stale; only control is scrubbed so nothing downstream acts on it.
            state_r     <= ST_EMPTY;
            valid_r     <= 1'b0;
            head_ctrl_r <= {CTRL_W{1'b0}};
            skid_ctrl_r <= {CTRL_W{1'b0}};
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (acc_s) begin
                        state_r     <= ST_FULL;
                        valid_r     <= 1'b1;
                        head_ctrl_r <= in_ctrl_s;
                        head_data_r <= in_data_i;
                        head_addr_r <= in_addr_i;
                    end
                end
                ST_FULL: begin
                    if (acc_s && pop_s) begin
                        head_ctrl_r <= in_ctrl_s;
                        head_data_r <= in_data_i;
                        head_addr_r <= in_addr_i;
                    end else if (acc_s) begin
                        state_r     <= ST_SKID;
                        skid_ctrl_r <= in_ctrl_s;
                        skid_data_r <= in_data_i;
                        skid_addr_r <= in_addr_i;
                    end else if (pop_s) begin
                        state_r <= ST_EMPTY;
                        valid_r <= 1'b0;
                    end
                end
                ST_SKID: begin
                    if (pop_s) begin
                        state_r     <= ST_FULL;
                        head_ctrl_r <= skid_ctrl_r;
                        head_data_r <= skid_data_r;
                        head_addr_r <= skid_addr_r;
                    end
                end
                default: begin
                    state_r <= ST_EMPTY;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef PIPE_STAGE_STAT_EN
    logic [15:0] stall_cnt_r;
    logic [15:0] flush_cnt_r;

    // Saturating back-pressure and flush event counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_r <= 16'h0000;
            flush_cnt_r <= 16'h0000;
        end else begin
            if (valid_r && !out_ready_i && (stall_cnt_r != 16'hFFFF)) begin
                stall_cnt_r <= stall_cnt_r + 16'h0001;
            end
            if (flush_i && (flush_cnt_r != 16'hFFFF)) begin
                flush_cnt_r <= flush_cnt_r + 16'h0001;
            end
        end
    end

    assign stall_cnt_o = stall_cnt_r;
    assign flush_cnt_o = flush_cnt_r;
`else
    assign stall_cnt_o = 16'h0000;
    assign flush_cnt_o = 16'h0000;
`endif

endmodule
